// File: rtl/sound_wave_ctrl_if.sv
// CPU-side bus of the channel 3 front end: address, write data, strobes and
// the combinational read data / address-hit returned by the block.
interface sound_wave_ctrl_if;
  // No back-pressure: a write is taken on every clk edge where wr is high,
  // and dout/hit follow a combinationally; rd only marks the cycle as a read.
  logic [15:0] a;
  logic [7:0]  din;
  logic        wr;
  logic        rd;
  logic [7:0]  dout;
  logic        hit;

  modport master (output a, din, wr, rd, input dout, hit);
  modport slave  (input a, din, wr, rd, output dout, hit);
endinterface

// File: rtl/sound_wave_ctrl.sv
// Channel 3 register file (NR30-NR34), trigger pulse stretcher and wave RAM
// front end with CPU/player arbitration while the channel is playing.
module sound_wave_ctrl #(
  parameter int START_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  sound_wave_ctrl_if.slave   bus,
  input  logic               sound_enable,
  input  logic               ch_enable,
  output logic               on,
  output logic [7:0]         length,
  output logic [1:0]         volume,
  output logic [10:0]        frequency,
  output logic               single,
  output logic               start,
  input  logic [3:0]         wave_a,
  output logic [7:0]         wave_d,
  output logic               ch3_status
);

  localparam logic [3:0] START_LOAD = 4'(START_CYCLES);

  logic [3:0] start_cnt;
  logic [7:0] ram [16];
  logic       reg_hit;
  logic       wave_hit;
  logic       reg_wr;
  logic       trigger;
  logic [3:0] wave_idx;

  assign reg_hit    = (bus.a >= 16'hFF1A) && (bus.a <= 16'hFF1E);
  assign wave_hit   = (bus.a[15:4] == 12'hFF3);
  assign bus.hit    = reg_hit | wave_hit;
  assign ch3_status = on & ch_enable;

  // While the channel plays the CPU is redirected to the byte the player is on.
  assign wave_idx = ch3_status ? wave_a : bus.a[3:0];

  assign reg_wr  = bus.wr & sound_enable & reg_hit;
  // Writing FF1E never changes on, so the current on is the post-write value.
  assign trigger = reg_wr && (bus.a[2:0] == 3'h6) && bus.din[7] && on;

  assign start = (start_cnt != 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      on        <= 1'b0;
      length    <= 8'h00;
      volume    <= 2'b00;
      frequency <= 11'h000;
      single    <= 1'b0;
      start_cnt <= 4'd0;
    end else if (!sound_enable) begin
      on        <= 1'b0;
      length    <= 8'h00;
      volume    <= 2'b00;
      frequency <= 11'h000;
      single    <= 1'b0;
      start_cnt <= 4'd0;
    end else begin
      if (reg_wr) begin
        case (bus.a[2:0])
          3'h2: on              <= bus.din[7];
          3'h3: length          <= bus.din;
          3'h4: volume          <= bus.din[6:5];
          3'h5: frequency[7:0]  <= bus.din;
          3'h6: begin
            frequency[10:8] <= bus.din[2:0];
            single          <= bus.din[6];
          end
          default: ;
        endcase
      end
      if (trigger)
        start_cnt <= START_LOAD;
      else if (start_cnt != 4'd0)
        start_cnt <= start_cnt - 4'd1;
    end
  end

  // Wave RAM keeps its contents across reset and sound_enable.
  always_ff @(posedge clk) begin
    if (bus.wr && wave_hit)
      ram[wave_idx] <= bus.din;
  end

  assign wave_d = ram[wave_a];

  always_comb begin
    bus.dout = 8'hFF;
    if (reg_hit) begin
      case (bus.a[2:0])
        3'h2:    bus.dout = {on, 7'h7F};
        3'h4:    bus.dout = {1'b1, volume, 5'h1F};
        3'h6:    bus.dout = {1'b1, single, 6'h3F};
        default: bus.dout = 8'hFF;
      endcase
    end else if (wave_hit) begin
      bus.dout = ram[wave_idx];
    end
  end

endmodule

// File: doc/sound_wave_ctrl.md
Name: sound_wave_ctrl

Overview:
- Channel 3 register and wave-RAM front end; sits directly upstream of the channel 3 wave player.
- Decodes CPU accesses to NR30–NR34 (FF1A–FF1E) and wave RAM (FF30–FF3F).
- Holds the channel 3 control state and generates a clean, stretched start pulse on trigger.
- Serves wave samples to the player and arbitrates CPU wave-RAM access while the channel plays.

Parameters:
- START_CYCLES, 2: clk cycles the start output stays high after an accepted trigger (1..15).

Ports:
- clk  input  1  main CPU clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- a  input  16  CPU address.
- din  input  8  CPU write data.
- wr  input  1  CPU write strobe; one write per cycle it is high.
- rd  input  1  CPU read strobe.
- dout  output  8  CPU read data; combinational.
- hit  output  1  high when a is in FF1A–FF1E or FF30–FF3F; combinational.
- sound_enable  input  1  NR52 bit 7 master enable.
- ch_enable  input  1  enable from the player's length counter.
- on  output  1  NR30 bit 7 (DAC on).
- length  output  8  NR31.
- volume  output  2  NR32 bits 6:5.
- frequency  output  11  {NR34[2:0], NR33}.
- single  output  1  NR34 bit 6.
- start  output  1  trigger pulse to the player.
- wave_a  input  4  player wave-RAM byte address.
- wave_d  output  8  wave RAM byte at wave_a; combinational.
- ch3_status  output  1  on & ch_enable, for NR52 bit 2.

Behaviour:
- Reset: on, length, volume, frequency, single, start all 0; start counter 0.
  - Wave RAM contents are not reset.
  - ch3_status follows its equation.
- Register writes (wr=1, sound_enable=1, a hits) take effect next edge:
  - FF1A: on <= din[7].
  - FF1B: length <= din.
  - FF1C: volume <= din[6:5].
  - FF1D: frequency[7:0] <= din.
  - FF1E: frequency[10:8] <= din[2:0]; single <= din[6]; din[7] = trigger.
- Writes to FF1A–FF1E while sound_enable=0 are ignored.
- sound_enable 1->0:
  - Synchronously clears on, length, volume, frequency, single.
  - Aborts any start pulse in progress (counter to 0, start low next cycle).
  - Wave RAM is kept.
- Trigger accepted only if the post-write value of on is 1:
  - Counter loads START_CYCLES; start = (counter != 0).
  - Counter decrements each cycle; start is high exactly START_CYCLES cycles, beginning the cycle after the write.
  - Trigger with on=0 is ignored.
  - Re-trigger during a pulse reloads the counter; start stays high continuously.
  - Writing on=0 during a pulse does not cut the pulse.
- Reads (hit=1, combinational; rd only qualifies the bus):
  - FF1A: {on, 7'h7F}
  - FF1B: FF
  - FF1C: {1, volume, 5'h1F}
  - FF1D: FF
  - FF1E: {1, single, 6'h3F}
  - Non-hit address: dout = FF.
- Wave RAM: 16x8, byte i at FF30+i; wave_d = ram[wave_a] combinationally.
- Playing state: playing = ch3_status.
  - playing=0: CPU read returns ram[a[3:0]]; CPU write stores to ram[a[3:0]].
  - playing=1: CPU read returns ram[wave_a]; CPU write stores to ram[wave_a].
  - Wave RAM access is independent of sound_enable.
- CPU write and player read of the same byte in the same cycle:
  - wave_d shows the old value that cycle and the new value from the next cycle.
- Reset asserted mid-pulse: start drops immediately (asynchronous).

Test Plan:
- Reset, then read FF1A, FF1C, FF1E -> 7F, 9F, BF; start=0; on=0.
- sound_enable=1; write FF1A=80, FF1D=34, FF1E=C5 -> frequency=0x534, single=1, start high exactly 2 cycles starting next edge; FF1E reads FF.
- on=0, write FF1E=80 -> start never rises; then write FF1E=80 twice 1 cycle apart with on=1 -> start high 3 consecutive cycles.
- Write FF30..FF3F = 00,11,..,FF with ch_enable=0 -> wave_a=5 gives wave_d=55; read FF37 -> 77.
- on=1, ch_enable=1, wave_a=3: read FF3A -> 33; write FF3A=AB -> ram[3]=AB, ram[10] unchanged.
- Mid-pulse sound_enable 1->0 -> start low next cycle, on/length/volume/frequency=0, FF1A reads 7F, wave RAM retained; FF1B write ignored while disabled.
